// File: rtl/adder_checker.sv
// Scoreboard for an adder DUT: predicts exact sums through a LATENCY-deep delay line,
// counts compares and mismatches. Define ADDER_CHECKER_FIRST_ERR_EN to capture the first mismatch.
module adder_checker #(
  parameter int WIDTH      = 16,
  parameter int LATENCY    = 1,
  parameter int NUM_CHECKS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH:0]   i_sum,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [15:0]      o_check_cnt,
  output logic [15:0]      o_err_cnt,
  output logic             o_first_err_valid,
  output logic [WIDTH:0]   o_first_err_exp,
  output logic [WIDTH:0]   o_first_err_got
);

  // state | meaning
  // IDLE  | waiting for first start after reset
  // RUN   | predicting and comparing sums
  // DONE  | NUM_CHECKS compares made, results held
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;
  localparam logic [15:0] NUM_CHK = 16'(NUM_CHECKS);

  state_t         state, state_nxt;
  logic           dl_vld [LATENCY];
  logic [WIDTH:0] dl_sum [LATENCY];
  logic [WIDTH:0] sum_in;
  logic           cmp, mismatch, start_run;
  logic [15:0]    chk_nxt, err_nxt;

  assign sum_in = {1'b0, i_a} + {1'b0, i_b};
  assign o_busy = (state == RUN);
  assign o_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    cmp       = 1'b0;
    mismatch  = 1'b0;
    chk_nxt   = o_check_cnt;
    err_nxt   = o_err_cnt;
    if (state == RUN && dl_vld[LATENCY-1]) begin
      cmp      = 1'b1;
      mismatch = (i_sum != dl_sum[LATENCY-1]);
      if (o_check_cnt != CNT_MAX) chk_nxt = o_check_cnt + 16'd1;
      if (mismatch && o_err_cnt != CNT_MAX) err_nxt = o_err_cnt + 16'd1;
    end
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          state_nxt = RUN;
          start_run = 1'b1;
        end
      end
      RUN:     if (cmp && chk_nxt == NUM_CHK) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Delay line only shifts while the run continues; any entry/exit of RUN flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        dl_vld[i] <= 1'b0;
        dl_sum[i] <= '0;
      end
      o_check_cnt <= '0;
      o_err_cnt   <= '0;
      o_pass      <= 1'b0;
    end else if (start_run) begin
      for (int i = 0; i < LATENCY; i++) begin
        dl_vld[i] <= 1'b0;
        dl_sum[i] <= '0;
      end
      o_check_cnt <= '0;
      o_err_cnt   <= '0;
      o_pass      <= 1'b0;
    end else if (state == RUN) begin
      o_check_cnt <= chk_nxt;
      o_err_cnt   <= err_nxt;
      if (state_nxt == DONE) begin
        o_pass <= (err_nxt == 16'd0);
        for (int i = 0; i < LATENCY; i++) begin
          dl_vld[i] <= 1'b0;
          dl_sum[i] <= '0;
        end
      end else begin
        for (int i = LATENCY - 1; i > 0; i--) begin
          dl_vld[i] <= dl_vld[i-1];
          dl_sum[i] <= dl_sum[i-1];
        end
        dl_vld[0] <= i_valid;
        dl_sum[0] <= i_valid ? sum_in : '0;
      end
    end
  end

`ifdef ADDER_CHECKER_FIRST_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_first_err_valid <= 1'b0;
      o_first_err_exp   <= '0;
      o_first_err_got   <= '0;
    end else if (start_run) begin
      o_first_err_valid <= 1'b0;
      o_first_err_exp   <= '0;
      o_first_err_got   <= '0;
    end else if (mismatch && !o_first_err_valid) begin
      o_first_err_valid <= 1'b1;
      o_first_err_exp   <= dl_sum[LATENCY-1];
      o_first_err_got   <= i_sum;
    end
  end
`else
  assign o_first_err_valid = 1'b0;
  assign o_first_err_exp   = '0;
  assign o_first_err_got   = '0;
`endif

endmodule

// File: doc/adder_checker.md
ADDER_CHECKER -- requirements
Module: adder_checker

Interface
REQ-001 Parameter WIDTH, 16, operand width; sum width is WIDTH+1.
REQ-002 Parameter LATENCY, 1, DUT cycles from operand sample to sum valid; legal range 1..4.
REQ-003 Parameter NUM_CHECKS, 20, number of comparisons per run; legal range 1..65535.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  single-cycle pulse that starts a run.
REQ-007 i_valid  in  1  i_a/i_b presented to the DUT this cycle.
REQ-008 i_a, i_b  in  WIDTH  operands driven to the DUT.
REQ-009 i_sum  in  WIDTH+1  DUT result.
REQ-010 o_busy  out  1  run in progress.
REQ-011 o_done  out  1  run complete; held until next start.
REQ-012 o_pass  out  1  valid only with o_done; 1 = zero mismatches.
REQ-013 o_check_cnt, o_err_cnt  out  16  comparisons made, mismatches seen.
REQ-014 o_first_err_valid  out  1; o_first_err_exp, o_first_err_got  out  WIDTH+1 each: first-mismatch capture.

Function
REQ-015 FSM states IDLE, RUN, DONE; IDLE->RUN on i_start; RUN->DONE when o_check_cnt reaches NUM_CHECKS; DONE->RUN on i_start; i_start in RUN ignored.
REQ-016 Entering RUN clears both counters, the delay line and all first-error outputs, and drops o_done and o_pass in the same edge.
REQ-017 In RUN, i_valid=1 pushes {1, i_a+i_b zero-extended to WIDTH+1} into a LATENCY-deep shift register; i_valid=0 pushes an invalid entry.
REQ-018 Expected sum is exact: carry kept in bit WIDTH, no truncation, no wrap.
REQ-019 When the tail entry is valid in RUN, i_sum is compared with it that cycle; o_check_cnt increments and, on inequality, o_err_cnt increments.
REQ-020 Counters saturate at 16'hFFFF.
REQ-021 The compare that brings o_check_cnt to NUM_CHECKS is counted; DONE is entered on that edge, and o_pass is set to (o_err_cnt after that compare == 0).
REQ-022 Entries still in the delay line on entering DONE are discarded, not compared.
REQ-023 In IDLE and DONE, i_valid and i_sum are ignored and counters hold.
REQ-024 o_busy = 1 exactly in RUN; o_done = 1 exactly in DONE.

Reset
REQ-025 rst_n low asynchronously forces IDLE and clears the delay line; all outputs go to 0.
REQ-026 Reset asserted mid-run abandons the run; no counts survive, and a new i_start is required after release.
REQ-027 Outputs change only on clk rising edges after rst_n deasserts.

Configuration
REQ-028 Macro ADDER_CHECKER_FIRST_ERR_EN defined: on the first mismatch of a run, o_first_err_valid sets and expected/got are latched; later mismatches do not overwrite them.
REQ-029 Macro undefined: o_first_err_valid, o_first_err_exp and o_first_err_got are tied to 0; no capture registers are built; all other behaviour is unchanged.

Verification
REQ-030 Reset, start, 20 valid pairs into a correct LATENCY=1 model -> o_done after the 20th compare, o_pass=1, check=20, err=0.
REQ-031 a=16'hFFFF, b=16'h0001, model returns 17'h10000 -> no error; model returns 17'h00000 -> err=1, first_err_exp=17'h10000, got=0 (with macro).
REQ-032 LATENCY=3 with i_valid toggling 1,0,1,0 -> only valid entries are compared, 3 cycles after sampling; invalid cycles leave the counters unchanged.
REQ-033 Errors injected on the 2nd and 5th checks -> err=2, o_pass=0, first_err holds the 2nd-check values.
REQ-034 rst_n pulsed low mid-run (check=7) -> all outputs 0 immediately, IDLE; new start gives a clean run from 0.
REQ-035 i_start during RUN ignored; i_start in DONE clears counters and starts a new run in the same edge; NUM_CHECKS=1 finishes on the first compare.
